// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source count, FSM states,
// register offsets and a one-hot helper.
package irq_pkg;

  localparam int NSRC = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_MODE = 2'd1;
  localparam logic [1:0] IRQ_PEND = 2'd2;
  localparam logic [1:0] IRQ_STAT = 2'd3;

  localparam int SRC_TIMER0 = 0;
  localparam int SRC_TIMER1 = 1;
  localparam int SRC_EXT    = 2;

  function automatic logic [NSRC-1:0] id_onehot(input logic [2:0] id);
    id_onehot = 6'b000001 << id;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Bridge-side register bus of the interrupt controller (word offset, write
// strobe, write data, combinational read data).
interface irq_ctrl_if;

  logic [1:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output We, output Din, input Dout);
  modport slave  (input Addr, input We, input Din, output Dout);

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder over the eligible sources.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [NSRC-1:0] req_i,
  output logic [2:0]      idx_o,
  output logic            valid_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o   = 3'd0;
    valid_o = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 3'(i);
        valid_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: latches source requests, masks them,
// presents one source at a time to the CPU and holds it in service until EOI.
module irq_ctrl
  import irq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] src,
  input  logic            int_ack,
  output logic [NSRC-1:0] HWInt,
  output logic            busy
);

  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] hwint_q, hwint_d;
  logic            busy_q, busy_d;
  irq_state_e      state_q, state_d;
  logic [2:0]      id_q, id_d;

  logic            wr_mask_s, wr_mode_s, wr_pend_s, wr_eoi_s;
  logic [NSRC-1:0] eligible_s, mode_chg_s, w1c_s, ack_clr_s, rise_s, edge_next_s;
  logic [2:0]      win_id_s;
  logic            win_valid_s;
  logic [31:0]     rdata_s;

  assign wr_mask_s  = bus.We && (bus.Addr == IRQ_MASK);
  assign wr_mode_s  = bus.We && (bus.Addr == IRQ_MODE);
  assign wr_pend_s  = bus.We && (bus.Addr == IRQ_PEND);
  assign wr_eoi_s   = bus.We && (bus.Addr == IRQ_STAT);
  assign eligible_s = pend_q & mask_q;

  irq_prio_enc u_prio (
    .req_i   (eligible_s),
    .idx_o   (win_id_s),
    .valid_o (win_valid_s)
  );

  // Register file next-state and pending-bit update.
  always_comb begin
    mask_d     = mask_q;
    mode_d     = mode_q;
    mode_chg_s = '0;
    w1c_s      = '0;
    ack_clr_s  = '0;
    if (wr_mask_s) begin
      mask_d = bus.Din[NSRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_mode_s) begin
      mode_d     = bus.Din[NSRC-1:0];
      mode_chg_s = bus.Din[NSRC-1:0] ^ mode_q;
    end else begin
      mode_d     = mode_q;
      mode_chg_s = '0;
    end
    if (wr_pend_s) begin
      w1c_s = bus.Din[NSRC-1:0];
    end else begin
      w1c_s = '0;
    end
    if ((state_q == REQ) && int_ack) begin
      ack_clr_s = id_onehot(id_q);
    end else begin
      ack_clr_s = '0;
    end
    // A new rising edge outranks any clear landing on the same edge.
    rise_s      = src & ~src_q;
    edge_next_s = (pend_q & ~(w1c_s | ack_clr_s)) | rise_s;
    pend_d      = ((mode_q & edge_next_s) | (~mode_q & src)) & ~mode_chg_s;
  end

  // Request / service FSM and the registered CPU-facing outputs.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          state_d = REQ;
          id_d    = win_id_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
        end else if (!eligible_s[id_q]) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (wr_eoi_s) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
        id_d    = 3'd0;
      end
    endcase
    if (state_d == REQ) begin
      hwint_d = id_onehot(id_d);
    end else begin
      hwint_d = '0;
    end
    busy_d = (state_d != IDLE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      src_q   <= '0;
      state_q <= IDLE;
      id_q    <= 3'd0;
      hwint_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      src_q   <= src;
      state_q <= state_d;
      id_q    <= id_d;
      hwint_q <= hwint_d;
      busy_q  <= busy_d;
    end
  end

  // Combinational register read mux.
  always_comb begin
    case (bus.Addr)
      IRQ_MASK: rdata_s = {26'd0, mask_q};
      IRQ_MODE: rdata_s = {26'd0, mode_q};
      IRQ_PEND: rdata_s = {26'd0, pend_q};
      IRQ_STAT: rdata_s = {27'd0, state_q, id_q};
      default:  rdata_s = 32'd0;
    endcase
  end

  assign bus.Dout = rdata_s;
  assign HWInt    = hwint_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios followed by random traffic, each cycle compared with a
// source-by-source reference model of the controller.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_s = 1'b1;
  logic [5:0]  src_s = 6'd0;
  logic        ack_s = 1'b0;
  logic [1:0]  addr_s = 2'd0;
  logic        we_s = 1'b0;
  logic [31:0] din_s = 32'd0;
  logic [5:0]  hwint_s;
  logic        busy_s;

  int checks = 0;
  int errors = 0;

  bit [5:0] m_mask, m_mode, m_pend, m_prev, m_hw;
  bit       m_busy;
  int       m_phase;  // 0 idle, 1 request, 2 service
  int       m_id;

  irq_ctrl_if bus_if ();
  assign bus_if.Addr = addr_s;
  assign bus_if.We   = we_s;
  assign bus_if.Din  = din_s;

  irq_ctrl dut (
    .clk     (clk),
    .reset   (reset_s),
    .bus     (bus_if.slave),
    .src     (src_s),
    .int_ack (ack_s),
    .HWInt   (hwint_s),
    .busy    (busy_s)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input bit [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_mask};
      2'd1:    return {26'd0, m_mode};
      2'd2:    return {26'd0, m_pend};
      default: return {27'd0, 2'(m_phase), 3'(m_id)};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit [5:0] elig, np;
    int w;
    if (reset_s) begin
      m_mask = 0; m_mode = 0; m_pend = 0; m_prev = 0; m_phase = 0; m_id = 0;
    end else begin
      elig = m_pend & m_mask;
      w = lowest(elig);
      np = m_pend;
      for (int i = 0; i < 6; i++) begin
        if (we_s && addr_s == 2'd1 && din_s[i] != m_mode[i]) np[i] = 1'b0;
        else if (m_mode[i]) begin
          if (src_s[i] && !m_prev[i]) np[i] = 1'b1;
          else if ((we_s && addr_s == 2'd2 && din_s[i]) ||
                   (ack_s && m_phase == 1 && m_id == i)) np[i] = 1'b0;
        end else np[i] = src_s[i];
      end
      case (m_phase)
        0: if (w >= 0) begin m_phase = 1; m_id = w; end
        1: if (ack_s) m_phase = 2; else if (!elig[m_id]) m_phase = 0;
        2: if (we_s && addr_s == 2'd3) m_phase = 0;
        default: m_phase = 0;
      endcase
      if (we_s && addr_s == 2'd0) m_mask = din_s[5:0];
      if (we_s && addr_s == 2'd1) m_mode = din_s[5:0];
      m_pend = np;
      m_prev = src_s;
    end
    m_hw   = (m_phase == 1) ? (6'b000001 << m_id) : 6'd0;
    m_busy = (m_phase != 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("hwint_model", {26'd0, hwint_s}, {26'd0, m_hw});
    chk("busy_model", {31'd0, busy_s}, {31'd0, m_busy});
    chk("dout_model", bus_if.Dout, m_read(addr_s));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr_s = a; din_s = d; we_s = 1'b1;
    tick();
    we_s = 1'b0; din_s = 32'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr_s = a;
    #1;
    chk(tag, bus_if.Dout, exp);
  endtask

  task automatic do_reset();
    reset_s = 1'b1; src_s = 6'd0; ack_s = 1'b0; we_s = 1'b0;
    tick();
    reset_s = 1'b0;
    tick();
  endtask

  initial begin
    // Basic level-mode request, ack and EOI with the source still high
    do_reset();
    chk("reset_hwint", {26'd0, hwint_s}, 32'd0);
    rd_chk("reset_stat", 2'd3, 32'd0);
    wr(2'd0, 32'h01);
    src_s = 6'h01;
    tick();
    chk("lat_e0", {26'd0, hwint_s}, 32'h00);
    tick();
    chk("lat_e1", {26'd0, hwint_s}, 32'h01);
    rd_chk("stat_req", 2'd3, 32'h08);
    ack_s = 1'b1; tick(); ack_s = 1'b0;
    chk("ack_hwint", {26'd0, hwint_s}, 32'h00);
    rd_chk("stat_svc", 2'd3, 32'h10);
    wr(2'd3, 32'h0);
    tick();
    chk("eoi_rereq", {26'd0, hwint_s}, 32'h01);

    // Fixed priority among simultaneous edges
    do_reset();
    wr(2'd0, 32'h3F);
    wr(2'd1, 32'h3F);
    src_s = 6'h12; tick(); src_s = 6'h00; tick();
    chk("prio_first", {26'd0, hwint_s}, 32'h02);
    ack_s = 1'b1; tick(); ack_s = 1'b0;
    wr(2'd3, 32'h0);
    tick();
    chk("prio_second", {26'd0, hwint_s}, 32'h10);
    ack_s = 1'b1; tick(); ack_s = 1'b0;
    wr(2'd3, 32'h0);
    tick();
    rd_chk("pend_empty", 2'd2, 32'h0);

    // W1C colliding with a fresh rising edge
    do_reset();
    wr(2'd1, 32'h04);
    src_s = 6'h04; tick(); src_s = 6'h00; tick();
    rd_chk("pend_pre_w1c", 2'd2, 32'h04);
    src_s = 6'h04; addr_s = 2'd2; din_s = 32'h04; we_s = 1'b1;
    tick();
    we_s = 1'b0; din_s = 32'd0;
    rd_chk("set_wins", 2'd2, 32'h04);

    // Masking the requested source cancels without ack
    do_reset();
    wr(2'd0, 32'h01);
    src_s = 6'h01; tick(); tick();
    chk("cancel_pre", {26'd0, hwint_s}, 32'h01);
    wr(2'd0, 32'h0);
    tick();
    chk("cancel_hwint", {26'd0, hwint_s}, 32'h00);
    rd_chk("cancel_stat", 2'd3, 32'h00);
    src_s = 6'h00;

    // No nesting while in service
    do_reset();
    wr(2'd0, 32'h03);
    wr(2'd1, 32'h03);
    src_s = 6'h01; tick(); src_s = 6'h00; tick();
    ack_s = 1'b1; tick(); ack_s = 1'b0;
    src_s = 6'h02; tick(); src_s = 6'h00; tick();
    chk("svc_hold", {26'd0, hwint_s}, 32'h00);
    rd_chk("svc_pend", 2'd2, 32'h02);
    wr(2'd3, 32'h0);
    tick();
    chk("svc_eoi_next", {26'd0, hwint_s}, 32'h02);

    // Reset in SERVICE
    ack_s = 1'b1; tick(); ack_s = 1'b0;
    rd_chk("svc2_stat", 2'd3, 32'h11);
    reset_s = 1'b1; tick(); reset_s = 1'b0;
    chk("rst_hwint", {26'd0, hwint_s}, 32'h0);
    chk("rst_busy", {31'd0, busy_s}, 32'h0);
    rd_chk("rst_mask", 2'd0, 32'h0);
    rd_chk("rst_mode", 2'd1, 32'h0);
    rd_chk("rst_pend", 2'd2, 32'h0);
    rd_chk("rst_stat", 2'd3, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) src_s = src_s ^ 6'($urandom);
      we_s    = ($urandom_range(0, 3) == 0);
      addr_s  = 2'($urandom);
      din_s   = $urandom;
      ack_s   = ($urandom_range(0, 4) == 0);
      reset_s = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset_s = 1'b0; we_s = 1'b0; ack_s = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Programmable interrupt controller placed between the peripheral interrupt sources (timer0, timer1, external `interrupt` pin, three spare lines) and the CPU's `HWInt[7:2]` input. It latches source requests, applies a per-source mask and edge/level mode, picks one source by fixed priority and presents it to the CPU as a one-hot `HWInt` request. It holds that source in service until the handler writes end-of-interrupt (EOI). It is a bridge-mapped device of four word registers, written through the same PrAddr/PrWD/PrWrite path as the timers.

## Interface
- `NSRC`, 6: number of interrupt sources; maps to HWInt[7:2]. Fixed at 6 in this design.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock; every register cleared on the edge where it is high.
- `Addr`  in  2  word offset within device (PrAddr[3:2]).
- `We`  in  1  register write strobe from bridge.
- `Din`  in  32  write data.
- `Dout`  out  32  read data, combinational from Addr.
- `src`  in  6  raw source requests; bit0 = timer0 IRQ, bit1 = timer1 IRQ, bit2 = external interrupt, bits 3-5 spare.
- `int_ack`  in  1  one-cycle pulse from CPU when it enters the exception handler for a hardware interrupt.
- `HWInt`  out  6  registered one-hot request to CPU (bit i = source i).
- `busy`  out  1  registered; high in REQ or SERVICE.

## Operation
- Register map: offset 0 MASK[5:0] (RW, 1 = enabled); offset 1 MODE[5:0] (RW, 1 = edge, 0 = level); offset 2 PENDING[5:0] (R, write-1-to-clear for edge bits); offset 3 STATUS (R = {27'b0, state[1:0], id[2:0]}; any write = EOI). Upper read bits are zero.
- Sampling: `src_q <= src` every cycle.
- Edge source i: pending[i] is set on a cycle with src[i]=1 and src_q[i]=0. It is cleared by a W1C write or by int_ack while id==i. If a set and a clear occur in the same cycle, the set wins.
- Level source i: pending[i] <= src[i] every cycle. W1C and int_ack have no effect on it.
- Eligible set: `pending & MASK`. Winner = lowest set index; this is the fixed priority.
- FSM states:
  - IDLE: if eligible != 0, go to REQ and latch `id` = winner.
  - REQ: `HWInt = 1<<id`. If int_ack, go to SERVICE; an edge-mode pending[id] clears. If eligible[id] drops before int_ack (masked, W1C, or level source deasserted), return to IDLE with HWInt cleared.
  - SERVICE: HWInt = 0. Newly eligible sources stay pending and are not presented; there is no nesting. An EOI write returns to IDLE.
- An EOI write in IDLE or REQ is ignored.
- A higher-priority source arriving during REQ does not preempt; `id` stays fixed until ack or cancel.
- MODE change on bit i clears pending[i] on the same edge.

## Timing
- Reset values: MASK=0, MODE=0, PENDING=0, src_q=0, state=IDLE, id=0, HWInt=0, busy=0. Dout reads 0 at reset for all offsets.
- Latency: src[i] rises before edge E0, so pending[i] is set after E0. The FSM enters REQ after E1, with HWInt and busy valid in the cycle after E1. Total is 2 cycles from source to HWInt.
- int_ack sampled at edge Ek: state is SERVICE and HWInt=0 after Ek.
- EOI written at edge Ek: state is IDLE after Ek. If another source is eligible, REQ follows after Ek+1.
- Register writes take effect at the write edge. Reads reflect the post-edge value in the following cycle.
- Reset asserted in any state returns to IDLE on that edge. A src already high at reset release does not register as an edge: src_q is captured on the first cycle after release.

## Structure
- Shared package `irq_pkg`:
  - state enum {IDLE=2'd0, REQ=2'd1, SERVICE=2'd2}
  - register offsets IRQ_MASK=0, IRQ_MODE=1, IRQ_PEND=2, IRQ_STAT=3
  - NSRC=6
  - source index constants SRC_TIMER0=0, SRC_TIMER1=1, SRC_EXT=2
- One sub-module, `irq_prio_enc`: combinational 6-to-3 lowest-index priority encoder with a valid output.
- The FSM and register file stay in `irq_ctrl`.
- The bridge decodes the device address range and drives `We`.

## Test plan
- Reset, then MASK=6'h01 and MODE=0. Raise src[0] → HWInt=6'h01 exactly 2 cycles later and STATUS=0x08. Pulse int_ack → HWInt=0 and STATUS=0x10. Write EOI with src[0] still high → REQ again and HWInt=6'h01.
- MASK=6'h3F and MODE=6'h3F. Pulse src[4] and src[1] in the same cycle → HWInt=6'h02. Ack plus EOI → HWInt=6'h10. PENDING read at the end = 0.
- Edge mode on bit 2 with a W1C write to PENDING=0x04 in the same cycle as a new rising edge on src[2] → PENDING[2]=1 (set wins).
- In REQ for id=0, write MASK=0 → HWInt=0 next cycle and state=IDLE. No ack is required.
- In SERVICE, raise src[1] (edge, enabled) → HWInt stays 0 and PENDING=0x02. EOI → HWInt=6'h02 after 1 cycle.
- Assert reset mid-SERVICE → HWInt=0, busy=0, STATUS=0, and MASK/MODE/PENDING read 0 on the next cycle.
